// File: rtl/hazard_controller_pkg.sv
// ============================================================================
// Module      : hazard_controller_pkg
// Description : Shared forwarding-select encodings and sequencer state codes
//               for the 5-stage pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HAZARD_CONTROLLER_FWD_DEFS
`define HAZARD_CONTROLLER_FWD_DEFS
`define FORWARD_SRC_BITS_COUNT 2
`define NO_FORWARDING          2'd0
`define FORWARD_FROM_MEMORY    2'd1
`define FORWARD_FROM_WRITEBACK 2'd2
`endif

package hazard_controller_pkg;

    localparam int FWD_SEL_W = `FORWARD_SRC_BITS_COUNT;

    localparam logic [FWD_SEL_W-1:0] FWD_NONE = `NO_FORWARDING;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM  = `FORWARD_FROM_MEMORY;
    localparam logic [FWD_SEL_W-1:0] FWD_WB   = `FORWARD_FROM_WRITEBACK;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hazard_controller_if.sv
// ============================================================================
// Module      : hazard_controller_if
// Description : Decode-side hazard inputs and stall/flush/forward controls
//               exchanged between the datapath and the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0]              rs1_decode;
    logic [REG_ADDR_W-1:0]              rs2_decode;
    logic [REG_ADDR_W-1:0]              rd_decode;
    logic                               uses_rs1_decode;
    logic                               uses_rs2_decode;
    logic                               reg_write_decode;
    logic                               is_load_decode;
    logic                               is_mem_decode;
    logic                               branch_taken_execute;
    logic                               mem_ready;
    logic [`FORWARD_SRC_BITS_COUNT-1:0] forward_rs1;
    logic [`FORWARD_SRC_BITS_COUNT-1:0] forward_rs2;
    logic                               stall_fetch;
    logic                               stall_decode;
    logic                               flush_decode;
    logic                               flush_execute;
    logic                               freeze;
    logic [CNT_W-1:0]                   stall_cycles;

    modport master (
        output rs1_decode, rs2_decode, rd_decode,
        output uses_rs1_decode, uses_rs2_decode,
        output reg_write_decode, is_load_decode, is_mem_decode,
        output branch_taken_execute, mem_ready,
        input  forward_rs1, forward_rs2,
        input  stall_fetch, stall_decode, flush_decode, flush_execute,
        input  freeze, stall_cycles
    );

    modport slave (
        input  rs1_decode, rs2_decode, rd_decode,
        input  uses_rs1_decode, uses_rs2_decode,
        input  reg_write_decode, is_load_decode, is_mem_decode,
        input  branch_taken_execute, mem_ready,
        output forward_rs1, forward_rs2,
        output stall_fetch, stall_decode, flush_decode, flush_execute,
        output freeze, stall_cycles
    );

endinterface

`default_nettype wire

// File: rtl/hazard_controller_forward_select.sv
// ============================================================================
// Module      : forward_select
// Description : Picks the bypass source for one execute operand; the MEM stage
//               wins over WB and x0 is never bypassed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_select
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [REG_ADDR_W-1:0] rs_i,
    input  wire logic [REG_ADDR_W-1:0] mem_rd_i,
    input  wire logic                  mem_reg_write_i,
    input  wire logic [REG_ADDR_W-1:0] wb_rd_i,
    input  wire logic                  wb_reg_write_i,
    output logic      [FWD_SEL_W-1:0]  sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (rs_i != '0) begin
            if (mem_reg_write_i && (mem_rd_i == rs_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module      : hazard_controller
// Description : 5-stage pipeline sequencer: shadow register pipeline, operand
//               forwarding, load-use/branch stalls and flushes, memory freeze.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_controller_if.slave hz
);

    logic [REG_ADDR_W-1:0] ex_rs_q [2];
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  ex_reg_write_q;
    logic                  ex_is_load_q;
    logic                  ex_is_mem_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  mem_reg_write_q;
    logic                  mem_is_mem_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_reg_write_q;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;

    logic [REG_ADDR_W-1:0] dec_rs_w [2];
    logic [FWD_SEL_W-1:0]  fwd_w [2];
    logic                  freeze_w;
    logic                  load_use_w;
    logic                  branch_w;
    logic                  stall_w;
    logic                  flush_ex_w;

    assign dec_rs_w[0] = hz.rs1_decode;
    assign dec_rs_w[1] = hz.rs2_decode;

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        forward_select #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_forward_select (
            .rs_i            (ex_rs_q[g]),
            .mem_rd_i        (mem_rd_q),
            .mem_reg_write_i (mem_reg_write_q),
            .wb_rd_i         (wb_rd_q),
            .wb_reg_write_i  (wb_reg_write_q),
            .sel_o           (fwd_w[g])
        );
    end

    // Freeze is raised in the same cycle the stalled access is seen in MEM.
    always_comb begin
        state_d  = state_q;
        freeze_w = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_is_mem_q && !hz.mem_ready) begin
                    freeze_w = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    freeze_w = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign load_use_w = ex_is_load_q && (ex_rd_q != '0) &&
                        ((hz.uses_rs1_decode && (hz.rs1_decode == ex_rd_q)) ||
                         (hz.uses_rs2_decode && (hz.rs2_decode == ex_rd_q)));
    assign branch_w   = hz.branch_taken_execute && !freeze_w;
    assign stall_w    = load_use_w && !branch_w && !freeze_w;
    assign flush_ex_w = !freeze_w && (branch_w || load_use_w);

    assign stall_cnt_d = (stall_w || freeze_w) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            stall_cnt_q     <= '0;
            ex_rs_q[0]      <= '0;
            ex_rs_q[1]      <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_is_load_q    <= 1'b0;
            ex_is_mem_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            mem_is_mem_q    <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            if (!freeze_w) begin
                if (flush_ex_w) begin
                    ex_rs_q[0]     <= '0;
                    ex_rs_q[1]     <= '0;
                    ex_rd_q        <= '0;
                    ex_reg_write_q <= 1'b0;
                    ex_is_load_q   <= 1'b0;
                    ex_is_mem_q    <= 1'b0;
                end else begin
                    ex_rs_q[0]     <= dec_rs_w[0];
                    ex_rs_q[1]     <= dec_rs_w[1];
                    ex_rd_q        <= hz.rd_decode;
                    ex_reg_write_q <= hz.reg_write_decode;
                    ex_is_load_q   <= hz.is_load_decode;
                    ex_is_mem_q    <= hz.is_mem_decode;
                end
                mem_rd_q        <= ex_rd_q;
                mem_reg_write_q <= ex_reg_write_q;
                mem_is_mem_q    <= ex_is_mem_q;
                wb_rd_q         <= mem_rd_q;
                wb_reg_write_q  <= mem_reg_write_q;
            end
        end
    end

    assign hz.forward_rs1   = fwd_w[0];
    assign hz.forward_rs2   = fwd_w[1];
    assign hz.stall_fetch   = stall_w;
    assign hz.stall_decode  = stall_w;
    assign hz.flush_decode  = branch_w;
    assign hz.flush_execute = flush_ex_w;
    assign hz.freeze        = freeze_w;
    assign hz.stall_cycles  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module      : tb_hazard_controller
// Description : Directed-vector scoreboard bench for hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;
    import hazard_controller_pkg::*;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       ld;
        logic       mem;
    } dec_t;

    typedef struct {
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic        fz;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc_n;
    exp_t exp_q[$];

    hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

    hazard_controller #(
        .REG_ADDR_W (5),
        .CNT_W      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dec_t ins(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2,
                                 input logic rw, input logic ld, input logic mem);
        dec_t d;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
        d.u1 = u1; d.u2 = u2; d.rw = rw; d.ld = ld; d.mem = mem;
        return d;
    endfunction

    function automatic exp_t ex(input logic [1:0] f1, input logic [1:0] f2, input logic stl,
                                input logic fd, input logic fe, input logic fz,
                                input logic [31:0] cnt);
        exp_t e;
        e.f1 = f1; e.f2 = f2; e.sf = stl; e.sd = stl;
        e.fd = fd; e.fe = fe; e.fz = fz; e.cnt = cnt; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t z(input logic [31:0] cnt);
        return ex(FWD_NONE, FWD_NONE, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    task automatic step(input logic rst, input dec_t d, input logic br, input logic mr,
                        input exp_t e);
        @(posedge clk);
        #1;
        rst_n                   = rst;
        hz.rs1_decode           = d.rs1;
        hz.rs2_decode           = d.rs2;
        hz.rd_decode            = d.rd;
        hz.uses_rs1_decode      = d.u1;
        hz.uses_rs2_decode      = d.u2;
        hz.reg_write_decode     = d.rw;
        hz.is_load_decode       = d.ld;
        hz.is_mem_decode        = d.mem;
        hz.branch_taken_execute = br;
        hz.mem_ready            = mr;
        e.cyc = cyc_n;
        cyc_n++;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle presents a full set of outputs; compare against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("forward_rs1",   e.cyc, 32'(hz.forward_rs1),   32'(e.f1));
            chk("forward_rs2",   e.cyc, 32'(hz.forward_rs2),   32'(e.f2));
            chk("stall_fetch",   e.cyc, 32'(hz.stall_fetch),   32'(e.sf));
            chk("stall_decode",  e.cyc, 32'(hz.stall_decode),  32'(e.sd));
            chk("flush_decode",  e.cyc, 32'(hz.flush_decode),  32'(e.fd));
            chk("flush_execute", e.cyc, 32'(hz.flush_execute), 32'(e.fe));
            chk("freeze",        e.cyc, 32'(hz.freeze),        32'(e.fz));
            chk("stall_cycles",  e.cyc, hz.stall_cycles,       e.cnt);
        end
    end

    initial begin
        dec_t nop;
        checks = 0;
        errors = 0;
        cyc_n  = 0;
        nop    = ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b0;
        hz.rs1_decode = '0; hz.rs2_decode = '0; hz.rd_decode = '0;
        hz.uses_rs1_decode = 1'b0; hz.uses_rs2_decode = 1'b0;
        hz.reg_write_decode = 1'b0; hz.is_load_decode = 1'b0; hz.is_mem_decode = 1'b0;
        hz.branch_taken_execute = 1'b0; hz.mem_ready = 1'b1;

        step(0, nop, 0, 1, z(0));
        // MEM/WB both hold x5: MEM wins; then a WB-only bypass on rs2
        step(1, ins(5'd1,  5'd2,  5'd5,  1, 1, 1, 0, 0), 0, 1, z(0));
        step(1, ins(5'd3,  5'd4,  5'd5,  1, 1, 1, 0, 0), 0, 1, z(0));
        step(1, ins(5'd5,  5'd9,  5'd8,  1, 1, 1, 0, 0), 0, 1, z(0));
        step(1, ins(5'd1,  5'd5,  5'd10, 1, 1, 1, 0, 0), 0, 1, ex(FWD_MEM, FWD_NONE, 0, 0, 0, 0, 0));
        step(1, nop, 0, 1, ex(FWD_NONE, FWD_WB, 0, 0, 0, 0, 0));
        step(1, nop, 0, 1, z(0));
        // lw x6 followed by a dependent add
        step(1, ins(5'd2,  5'd0,  5'd6,  1, 0, 1, 1, 1), 0, 1, z(0));
        step(1, ins(5'd6,  5'd1,  5'd7,  1, 1, 1, 0, 0), 0, 1, ex(FWD_NONE, FWD_NONE, 1, 0, 1, 0, 0));
        step(1, ins(5'd6,  5'd1,  5'd7,  1, 1, 1, 0, 0), 0, 1, z(1));
        step(1, nop, 0, 1, ex(FWD_WB, FWD_NONE, 0, 0, 0, 0, 1));
        // x0 is never bypassed and lw x0 never stalls
        step(1, ins(5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0), 0, 1, z(1));
        step(1, ins(5'd0,  5'd0,  5'd11, 1, 1, 1, 0, 0), 0, 1, z(1));
        step(1, ins(5'd3,  5'd0,  5'd0,  1, 0, 1, 1, 1), 0, 1, z(1));
        step(1, ins(5'd0,  5'd4,  5'd12, 1, 1, 1, 0, 0), 0, 1, z(1));
        step(1, ins(5'd1,  5'd1,  5'd20, 1, 1, 1, 0, 0), 0, 1, z(1));
        // store waits three cycles in MEM; EX keeps its WB bypass throughout
        step(1, ins(5'd2,  5'd9,  5'd0,  1, 1, 0, 0, 1), 0, 1, z(1));
        step(1, ins(5'd20, 5'd2,  5'd13, 1, 1, 1, 0, 0), 0, 1, z(1));
        step(1, ins(5'd13, 5'd3,  5'd14, 1, 1, 1, 0, 0), 0, 0, ex(FWD_WB, FWD_NONE, 0, 0, 0, 1, 1));
        step(1, ins(5'd13, 5'd3,  5'd14, 1, 1, 1, 0, 0), 0, 0, ex(FWD_WB, FWD_NONE, 0, 0, 0, 1, 2));
        step(1, ins(5'd13, 5'd3,  5'd14, 1, 1, 1, 0, 0), 1, 0, ex(FWD_WB, FWD_NONE, 0, 0, 0, 1, 3));
        step(1, ins(5'd13, 5'd3,  5'd14, 1, 1, 1, 0, 0), 0, 1, ex(FWD_WB, FWD_NONE, 0, 0, 0, 0, 4));
        step(1, nop, 0, 0, ex(FWD_MEM, FWD_NONE, 0, 0, 0, 0, 4));
        // load-use coinciding with a taken branch
        step(1, ins(5'd2,  5'd0,  5'd6,  1, 0, 1, 1, 1), 0, 1, z(4));
        step(1, ins(5'd6,  5'd1,  5'd7,  1, 1, 1, 0, 0), 1, 1, ex(FWD_NONE, FWD_NONE, 0, 1, 1, 0, 4));
        // reset arriving during a memory wait
        step(1, ins(5'd1,  5'd2,  5'd15, 1, 1, 1, 0, 0), 0, 1, z(4));
        step(1, ins(5'd2,  5'd15, 5'd0,  1, 1, 0, 0, 1), 0, 1, z(4));
        step(1, ins(5'd15, 5'd0,  5'd16, 1, 0, 1, 0, 0), 0, 1, ex(FWD_NONE, FWD_MEM, 0, 0, 0, 0, 4));
        step(1, nop, 0, 0, ex(FWD_WB, FWD_NONE, 0, 0, 0, 1, 4));
        step(1, nop, 0, 0, ex(FWD_WB, FWD_NONE, 0, 0, 0, 1, 5));
        step(0, nop, 0, 0, z(0));
        step(1, nop, 0, 0, z(0));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
